// File: rtl/mul_div_unit_if.sv
// ============================================================================
// mul_div_unit_if : issue/result bundle between the E stage and mul_div_unit
// Revision 1.0
// ============================================================================
`default_nettype none

interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, flush,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, flush,
    output busy, stall_req, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : multi-cycle HI/LO multiply/divide unit (mult/multu/div/divu)
// Revision 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mul_div_unit_if.slave   bus
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_MULT_N = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_N  = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]           r_op, w_op_nxt;
  logic [31:0]          r_a, w_a_nxt;
  logic [31:0]          r_b, w_b_nxt;
  logic [31:0]          r_hi, w_hi_nxt;
  logic [31:0]          r_lo, w_lo_nxt;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_sdiv;
  logic [31:0] w_dvd, w_dvs, w_uq, w_ur, w_q, w_r;
  logic        w_busy;

  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
  assign w_sdiv = (r_op == 2'b10);
  assign w_dvd  = (w_sdiv && r_a[31]) ? -r_a : r_a;
  assign w_dvs  = (w_sdiv && r_b[31]) ? -r_b : r_b;
  assign w_uq   = (w_dvs == 32'd0) ? 32'd0 : (w_dvd / w_dvs);
  assign w_ur   = (w_dvs == 32'd0) ? 32'd0 : (w_dvd % w_dvs);
  assign w_q    = (w_sdiv && (r_a[31] ^ r_b[31])) ? -w_uq : w_uq;
  assign w_r    = (w_sdiv && r_a[31]) ? -w_ur : w_ur;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= 2'b00;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      IDLE: begin
        if (!bus.flush) begin
          if (bus.start) begin
            w_op_nxt    = bus.op;
            w_a_nxt     = bus.a;
            w_b_nxt     = bus.b;
            w_cnt_nxt   = bus.op[1] ? c_DIV_N : c_MULT_N;
            w_state_nxt = RUN;
          end else begin
            if (bus.mthi) w_hi_nxt = bus.a;
            if (bus.mtlo) w_lo_nxt = bus.a;
          end
        end
      end
      RUN: begin
        if (r_cnt == c_ONE) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          if (!r_op[1]) begin
            {w_hi_nxt, w_lo_nxt} = r_op[0] ? w_prod_u : w_prod_s;
          end else if (r_b != 32'd0) begin
            w_hi_nxt = w_r;
            w_lo_nxt = w_q;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_busy        = (r_state == RUN);
  assign bus.busy      = w_busy;
  assign bus.stall_req = w_busy | bus.start;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// tb_mul_div_unit : self-checking bench for mul_div_unit with a reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  localparam int c_MULT_N = 5;
  localparam int c_DIV_N  = 10;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mul_div_unit_if bus ();

  mul_div_unit #(
    .MULT_CYCLES (c_MULT_N),
    .DIV_CYCLES  (c_DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference results from plain 64-bit arithmetic.
  task automatic model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sq, sr, sp;
    longint unsigned up;
    case (o)
      2'b00: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        m_hi = sp[63:32];
        m_lo = sp[31:0];
      end
      2'b01: begin
        up = longint'({32'd0, x}) * longint'({32'd0, y});
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      2'b10: begin
        if (y != 32'd0) begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          m_lo = sq[31:0];
          m_hi = sr[31:0];
        end
      end
      default: begin
        if (y != 32'd0) begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  // Issues one operation at a negedge and follows it until busy drops.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit flush_mid, input bit move_mid, input string name);
    int cyc;
    bit held;
    int n;
    n = o[1] ? c_DIV_N : c_MULT_N;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    #1;
    checks++;
    if (bus.stall_req !== 1'b1) begin
      errors++;
      $display("FAIL %s stall_req on issue: got %b want 1", name, bus.stall_req);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    cyc  = 0;
    held = 1'b1;
    while (bus.busy === 1'b1 && cyc < 64) begin
      cyc++;
      if (bus.hi !== m_hi || bus.lo !== m_lo || bus.stall_req !== 1'b1) held = 1'b0;
      if (cyc == 2) begin
        bus.flush = flush_mid;
        bus.mthi  = move_mid;
        bus.mtlo  = move_mid;
        bus.start = move_mid;
      end else if (cyc == 3) begin
        bus.flush = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    model_op(o, x, y);
    checks++;
    if (cyc != n) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d want %0d", name, cyc, n);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL %s hi/lo/stall_req not held during busy: got 0 want 1", name);
    end
    checks++;
    if (bus.hi !== m_hi) begin
      errors++;
      $display("FAIL %s hi: got %h want %h", name, bus.hi, m_hi);
    end
    checks++;
    if (bus.lo !== m_lo) begin
      errors++;
      $display("FAIL %s lo: got %h want %h", name, bus.lo, m_lo);
    end
  endtask

  task automatic do_move(input bit h, input bit l, input logic [31:0] x, input string name);
    bus.mthi = h;
    bus.mtlo = l;
    bus.a    = x;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    if (h) m_hi = x;
    if (l) m_lo = x;
    checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      errors++;
      $display("FAIL %s hi/lo: got %h/%h want %h/%h", name, bus.hi, bus.lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset state busy/stall/hi/lo: got %b/%b/%h/%h want 0/0/0/0",
               bus.busy, bus.stall_req, bus.hi, bus.lo);
    end
  endtask

  task automatic test_vectors();
    run_op(2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, "mult_neg2x3");
    checks++;
    if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL mult_neg2x3 const: got %h/%h want ffffffff/fffffffa", bus.hi, bus.lo);
    end
    run_op(2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, "multu_max_x2");
    checks++;
    if (bus.hi !== 32'h00000001 || bus.lo !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL multu_max_x2 const: got %h/%h want 00000001/fffffffe", bus.hi, bus.lo);
    end
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "div_neg7_2");
    checks++;
    if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_neg7_2 const: got %h/%h want ffffffff/fffffffd", bus.hi, bus.lo);
    end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div_overflow");
    checks++;
    if (bus.hi !== 32'h00000000 || bus.lo !== 32'h80000000) begin
      errors++;
      $display("FAIL div_overflow const: got %h/%h want 00000000/80000000", bus.hi, bus.lo);
    end
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
  endtask

  task automatic test_div_zero();
    do_move(1'b1, 1'b0, 32'h00001234, "mthi");
    do_move(1'b0, 1'b1, 32'h00005678, "mtlo");
    run_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0, "divu_by_zero");
    checks++;
    if (bus.hi !== 32'h00001234 || bus.lo !== 32'h00005678) begin
      errors++;
      $display("FAIL divu_by_zero const: got %h/%h want 00001234/00005678", bus.hi, bus.lo);
    end
    run_op(2'b10, 32'h80000000, 32'd0, 1'b0, 1'b0, "div_by_zero");
  endtask

  task automatic test_flush();
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
      errors++;
      $display("FAIL flush_start busy/hi/lo: got %b/%h/%h want 0/%h/%h",
               bus.busy, bus.hi, bus.lo, m_hi, m_lo);
    end
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.a    = 32'hDEADBEEF;
    @(negedge clk);
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.flush = 1'b0;
    checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      errors++;
      $display("FAIL flush_move hi/lo: got %h/%h want %h/%h", bus.hi, bus.lo, m_hi, m_lo);
    end
    bus.mthi = 1'b1;
    run_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b0, "start_with_mthi");
    run_op(2'b10, 32'hFFFFFF00, 32'd3, 1'b1, 1'b0, "flush_during_run");
    run_op(2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, "moves_while_busy");
  endtask

  task automatic test_reset_mid();
    run_op(2'b01, 32'hABCDEF01, 32'h11111111, 1'b0, 1'b0, "pre_reset_multu");
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid busy/hi/lo: got %b/%h/%h want 0/0/0", bus.busy, bus.hi, bus.lo);
    end
    run_op(2'b00, 32'd5, 32'hFFFFFFFD, 1'b0, 1'b0, "mult_after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(2'b11, 32'hFFFFFFFF, 32'd16, 1'b0, 1'b0, "b2b_divu");
    run_op(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, "b2b_mult");
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, "b2b_div");
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: y = -32'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) do_move(1'b1, 1'b1, $urandom, "rand_move");
      run_op(o, x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.flush = 1'b0;
    test_reset();
    test_vectors();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, meaning busy duration in cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, meaning busy duration in cycles for div/divu.
REQ-003 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high; clock clk.
REQ-005 The block SHALL have port start, input, 1 bit, E-stage mult/multu/div/divu issue strobe.
REQ-006 The block SHALL have port op, input, 2 bits: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 The block SHALL have port a, input, 32 bits, rs operand.
REQ-008 The block SHALL have port b, input, 32 bits, rt operand.
REQ-009 The block SHALL have port mthi, input, 1 bit, write a into HI.
REQ-010 The block SHALL have port mtlo, input, 1 bit, write a into LO.
REQ-011 The block SHALL have port flush, input, 1 bit, exception/interrupt cancels the E-stage instruction this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit, operation in progress.
REQ-013 The block SHALL have port stall_req, output, 1 bit, equal to busy | start; drives the pipeline stall.
REQ-014 The block SHALL have port hi, output, 32 bits, HI register.
REQ-015 The block SHALL have port lo, output, 32 bits, LO register.

Function
REQ-016 States SHALL be IDLE and RUN; a down-counter SHALL hold the remaining cycles.
REQ-017 In IDLE with start=1 and flush=0 at edge k, the block SHALL latch a, b and op, load the counter with N (MULT_CYCLES or DIV_CYCLES), and enter RUN.
REQ-018 busy SHALL be 1 from after edge k until edge k+N, i.e. exactly N cycles.
REQ-019 At edge k+N, hi and lo SHALL update and busy SHALL fall on the same edge.
REQ-020 hi and lo SHALL hold their previous values throughout RUN.
REQ-021 mult SHALL compute the signed 64-bit product, with {hi,lo} = a*b.
REQ-022 multu SHALL compute the same product unsigned.
REQ-023 div SHALL compute lo = signed quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-024 divu SHALL compute the unsigned quotient and remainder.
REQ-025 div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-026 For div/divu with b=0, the block SHALL still run DIV_CYCLES and leave hi and lo unchanged at completion.
REQ-027 In IDLE with mthi=1 (start=0, flush=0), hi SHALL take a at the next edge.
REQ-028 In IDLE with mtlo=1 (start=0, flush=0), lo SHALL take a at the next edge.
REQ-029 If start=1 in the same cycle as mthi or mtlo, start SHALL take priority and the move SHALL be ignored.
REQ-030 flush=1 SHALL suppress start, mthi and mtlo in that cycle, with no state change.
REQ-031 flush=1 during RUN SHALL NOT abort the operation; the issuing instruction has already committed.
REQ-032 start, mthi and mtlo SHALL be ignored while busy=1; the pipeline guarantees they are not issued then.
REQ-033 A new start SHALL be accepted in the cycle after busy falls, with no dead cycle.

Reset
REQ-034 reset=1 at a clock edge SHALL set hi=0, lo=0, busy=0, counter=0 and state to IDLE.
REQ-035 reset SHALL take priority over every other input.
REQ-036 reset mid-operation SHALL abort the operation with no hi/lo update.

Verification
REQ-037 mult a=0xFFFFFFFE (-2), b=3 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-038 multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
REQ-039 div a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-040 divu a=7, b=0 after mthi 0x1234 and mtlo 0x5678 -> busy for 10 cycles, then hi=0x1234, lo=0x5678 unchanged.
REQ-041 start with flush=1 -> busy stays 0 and hi/lo unchanged; start with mthi together -> mthi ignored.
REQ-042 reset asserted 3 cycles into a div -> busy=0 and hi=lo=0 after the edge; a following mult is accepted immediately.
